// File: rtl/duty_meter_pkg.sv
// Shared types and defaults for the duty-cycle meter.
package duty_meter_pkg;

    localparam int DEFAULT_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        MEAS_HIGH,
        MEAS_LOW
    } meter_state_t;

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchroniser for an asynchronous level, with registered edge detection.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            level_d <= 1'b0;
        end else begin
            // NOTE: non-blocking so every stage captures its neighbour's previous value.
            sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
            level_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~level_d;
    assign fall  = ~level & level_d;

endmodule

// File: rtl/duty_cycle_meter.sv
// Measures high time, low time and period of an asynchronous square wave in clk cycles,
// flags a stuck input, and counts rising edges while enabled.
module duty_cycle_meter
    import duty_meter_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic             meas_valid,
    output logic [CNT_W-1:0] high_cycles,
    output logic [CNT_W-1:0] low_cycles,
    output logic [CNT_W-1:0] period_cycles,
    output logic [CNT_W-1:0] edge_count,
    output logic             stuck
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    logic level, rise, fall;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_in(sig_in),
        .level   (level),
        .rise    (rise),
        .fall    (fall)
    );

    meter_state_t     state, state_next;
    logic [CNT_W-1:0] hi_cnt, lo_cnt;
    logic             start_hi, start_lo, latch_result, timeout, clear_cnt, count_edge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        state_next   = state;
        start_hi     = 1'b0;
        start_lo     = 1'b0;
        latch_result = 1'b0;
        timeout      = 1'b0;
        clear_cnt    = 1'b0;
        count_edge   = enable && (state != IDLE) && rise;

        if (!enable) begin
            state_next = IDLE;
            clear_cnt  = 1'b1;
        end else begin
            case (state)
                IDLE: state_next = WAIT_RISE;
                WAIT_RISE: begin
                    if (rise) begin
                        state_next = MEAS_HIGH;
                        start_hi   = 1'b1;
                    end
                end
                MEAS_HIGH: begin
                    // A phase that has hit the limit wins over a coincident edge.
                    if (hi_cnt >= TIMEOUT_CNT) begin
                        timeout    = 1'b1;
                        state_next = WAIT_RISE;
                    end else if (fall) begin
                        state_next = MEAS_LOW;
                        start_lo   = 1'b1;
                    end
                end
                MEAS_LOW: begin
                    if (lo_cnt >= TIMEOUT_CNT) begin
                        timeout    = 1'b1;
                        state_next = WAIT_RISE;
                    end else if (rise) begin
                        latch_result = 1'b1;
                        start_hi     = 1'b1;
                        state_next   = MEAS_HIGH;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else if (clear_cnt || timeout) begin
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else begin
            if (start_hi)
                hi_cnt <= ONE;
            else if (state == MEAS_HIGH && level && hi_cnt < TIMEOUT_CNT)
                hi_cnt <= hi_cnt + ONE;

            if (start_lo)
                lo_cnt <= ONE;
            else if (state == MEAS_LOW && !level && lo_cnt < TIMEOUT_CNT)
                lo_cnt <= lo_cnt + ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meas_valid    <= 1'b0;
            high_cycles   <= '0;
            low_cycles    <= '0;
            period_cycles <= '0;
            edge_count    <= '0;
            stuck         <= 1'b0;
        end else begin
            meas_valid <= latch_result;
            if (latch_result) begin
                high_cycles   <= hi_cnt;
                low_cycles    <= lo_cnt;
                period_cycles <= hi_cnt + lo_cnt;
            end

            if (timeout)           stuck <= 1'b1;
            else if (latch_result) stuck <= 1'b0;

            if (count_edge) edge_count <= edge_count + ONE;
        end
    end

endmodule

// File: tb/tb_duty_cycle_meter.sv
// Bench for duty_cycle_meter: timestamp-based reference model compared every cycle,
// directed scenarios with literal pins, then randomized waveforms and enable toggles.
module tb_duty_cycle_meter;

    localparam int CNT_W       = 32;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT_CYC = 1000;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             sig_in;
    logic             meas_valid;
    logic [CNT_W-1:0] high_cycles, low_cycles, period_cycles, edge_count;
    logic             stuck;

    int vectors     = 0;
    int miscompares = 0;
    int pulse_cnt   = 0;

    duty_cycle_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .sig_in       (sig_in),
        .meas_valid   (meas_valid),
        .high_cycles  (high_cycles),
        .low_cycles   (low_cycles),
        .period_cycles(period_cycles),
        .edge_count   (edge_count),
        .stuck        (stuck)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: the synchronised level is sig_in as sampled SYNC_STAGES-1 edges
    // earlier. Phases are tracked as timestamps of the rise/fall that opened them.
    logic [SYNC_STAGES:0] hist;
    int unsigned          now_cyc, t_rise, t_fall, phase_len;
    bit                   m_active, have_rise, have_fall, m_rise, m_fall;
    logic [CNT_W-1:0]     e_high, e_low, e_period, e_edges;
    bit                   e_valid, e_stuck;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist = '0; now_cyc = 0; t_rise = 0; t_fall = 0;
            m_active = 0; have_rise = 0; have_fall = 0;
            e_high = '0; e_low = '0; e_period = '0; e_edges = '0;
            e_valid = 0; e_stuck = 0;
        end else begin
            m_rise  = hist[SYNC_STAGES-1] && !hist[SYNC_STAGES];
            m_fall  = !hist[SYNC_STAGES-1] && hist[SYNC_STAGES];
            hist    = {hist[SYNC_STAGES-1:0], sig_in};
            e_valid = 0;
            if (!enable) begin
                m_active  = 0;
                have_rise = 0;
            end else if (!m_active) begin
                m_active  = 1;
                have_rise = 0;
            end else begin
                if (m_rise) e_edges = e_edges + 1;
                phase_len = have_fall ? now_cyc - t_fall : now_cyc - t_rise;
                if (have_rise && phase_len >= TIMEOUT_CYC) begin
                    e_stuck   = 1;
                    have_rise = 0;
                end else if (m_rise) begin
                    if (have_rise && have_fall) begin
                        e_high   = CNT_W'(t_fall - t_rise);
                        e_low    = CNT_W'(now_cyc - t_fall);
                        e_period = e_high + e_low;
                        e_valid  = 1;
                        e_stuck  = 0;
                    end
                    t_rise    = now_cyc;
                    have_rise = 1;
                    have_fall = 0;
                end else if (m_fall && have_rise && !have_fall) begin
                    t_fall    = now_cyc;
                    have_fall = 1;
                end
            end
            now_cyc++;
        end
    end

    always @(negedge clk) begin
        check("meas_valid", 64'(meas_valid), 64'(e_valid));
        check("high_cycles", 64'(high_cycles), 64'(e_high));
        check("low_cycles", 64'(low_cycles), 64'(e_low));
        check("period_cycles", 64'(period_cycles), 64'(e_period));
        check("edge_count", 64'(edge_count), 64'(e_edges));
        check("stuck", 64'(stuck), 64'(e_stuck));
        if (meas_valid === 1'b1) pulse_cnt++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // n periods, each low phase first then high phase, lengths in clk cycles.
    task automatic wave(input int lo, input int hi, input int n);
        for (int i = 0; i < n; i++) begin
            sig_in = 1'b0;
            cycles(lo);
            sig_in = 1'b1;
            cycles(hi);
        end
    endtask

    task automatic pin_result(input string tag, input int h, input int l, input int p,
                              input int edges, input int pulses, input bit stk);
        #1;
        check({tag, "_high"}, 64'(high_cycles), 64'(h));
        check({tag, "_low"}, 64'(low_cycles), 64'(l));
        check({tag, "_period"}, 64'(period_cycles), 64'(p));
        check({tag, "_edges"}, 64'(edge_count), 64'(edges));
        check({tag, "_pulses"}, 64'(pulse_cnt), 64'(pulses));
        check({tag, "_stuck"}, 64'(stuck), 64'(stk));
    endtask

    initial begin
        int lo, hi;
        reset_n = 1'b0;
        enable  = 1'b0;
        sig_in  = 1'b0;
        cycles(3);
        reset_n = 1'b1;
        pin_result("reset", 0, 0, 0, 0, 0, 0);
        check("reset_valid", 64'(meas_valid), 64'(0));

        // 30/70 ns square wave: four complete triplets from five rises
        enable = 1'b1;
        cycles(3);
        wave(7, 3, 5);
        pin_result("t1", 3, 7, 10, 5, 4, 0);

        // 50/50 ns: first triplet mixes the old high phase with the new low phase
        wave(5, 5, 1);
        pin_result("t2_mixed", 3, 5, 8, 6, 5, 0);
        wave(5, 5, 3);
        pin_result("t2_steady", 5, 5, 10, 9, 8, 0);

        // Stuck high past the timeout, then resume: one re-arming rise, then a result
        cycles(TIMEOUT_CYC + 200);
        pin_result("t3_stuck", 5, 5, 10, 9, 8, 1);
        wave(7, 3, 1);
        pin_result("t3_rearm", 5, 5, 10, 10, 8, 1);
        wave(7, 3, 1);
        pin_result("t3_resume", 3, 7, 10, 11, 9, 0);

        // Disable during the low phase: results and edge count hold, no pulse
        sig_in = 1'b0;
        cycles(4);
        enable = 1'b0;
        cycles(2);
        wave(7, 3, 2);
        pin_result("t4_off", 3, 7, 10, 11, 9, 0);
        enable = 1'b1;
        wave(7, 3, 1);
        pin_result("t4_rearm", 3, 7, 10, 12, 9, 0);
        wave(7, 3, 1);
        pin_result("t4_resume", 3, 7, 10, 13, 10, 0);

        // Asynchronous reset mid high phase
        cycles(2);
        #2;
        reset_n = 1'b0;
        sig_in  = 1'b0;
        #1;
        check("t5_valid", 64'(meas_valid), 64'(0));
        check("t5_high", 64'(high_cycles), 64'(0));
        check("t5_period", 64'(period_cycles), 64'(0));
        check("t5_edges", 64'(edge_count), 64'(0));
        @(negedge clk);
        reset_n   = 1'b1;
        pulse_cnt = 0;
        wave(7, 3, 3);
        pin_result("t5_fresh", 3, 7, 10, 3, 2, 0);

        // Single-cycle glitch inside a low phase
        sig_in = 1'b0; cycles(3);
        sig_in = 1'b1; cycles(1);
        sig_in = 1'b0; cycles(4);
        wave(7, 3, 3);

        // Random waveforms with occasional disable windows and near-timeout phases
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                enable = 1'b0;
                cycles(int'($urandom_range(1, 10)));
                enable = 1'b1;
            end
            lo = ($urandom_range(0, 49) == 0) ? int'($urandom_range(TIMEOUT_CYC - 3, TIMEOUT_CYC + 2))
                                              : int'($urandom_range(1, 12));
            hi = ($urandom_range(0, 49) == 0) ? int'($urandom_range(TIMEOUT_CYC - 3, TIMEOUT_CYC + 2))
                                              : int'($urandom_range(1, 12));
            wave(lo, hi, 1);
        end
        cycles(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
